// File: rtl/regfile_dump.sv
// regfile_dump: debug scan agent that walks a wrapping range of register-file
// addresses through one read port and streams {address, data} pairs out on a
// valid/ready interface, keeping a running XOR checksum of emitted words.
module regfile_dump #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
) (
    input  logic          inclk,
    input  logic          rstn,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [AW:0]   count,
    input  logic          abort,
    output logic [AW-1:0] rf_raddr,
    input  logic [DW-1:0] rf_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] checksum
);

    // Width of the remaining-word counter (holds 0..2**AW inclusive).
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_cur;
    logic [CW-1:0] r_rem;
    logic          r_out_valid;
    logic [AW-1:0] r_out_addr;
    logic [DW-1:0] r_out_data;
    logic [DW-1:0] r_checksum;
    logic          r_busy;
    logic          r_done;

    state_t        w_state_nxt;
    logic [AW-1:0] w_cur_nxt;
    logic [CW-1:0] w_rem_nxt;
    logic          w_out_valid_nxt;
    logic [AW-1:0] w_out_addr_nxt;
    logic [DW-1:0] w_out_data_nxt;
    logic [DW-1:0] w_checksum_nxt;
    logic          w_busy_nxt;
    logic          w_done_nxt;

    // Next-state and next-output decode; every next value defaults to hold.
    always_comb begin
        w_state_nxt     = r_state;
        w_cur_nxt       = r_cur;
        w_rem_nxt       = r_rem;
        w_out_valid_nxt = r_out_valid;
        w_out_addr_nxt  = r_out_addr;
        w_out_data_nxt  = r_out_data;
        w_checksum_nxt  = r_checksum;
        w_busy_nxt      = 1'b0;
        w_done_nxt      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_checksum_nxt = '0;
                    if (count != '0) begin
                        w_cur_nxt   = start_addr;
                        w_rem_nxt   = count;
                        w_state_nxt = ST_FETCH;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end

            ST_FETCH: begin
                if (abort) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end else begin
                    // rf_raddr has shown r_cur all cycle, so rf_rdata is settled.
                    w_out_data_nxt  = rf_rdata;
                    w_out_addr_nxt  = r_cur;
                    w_out_valid_nxt = 1'b1;
                    w_checksum_nxt  = r_checksum ^ rf_rdata;
                    w_state_nxt     = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (abort) begin
                    // Word is dropped but stays folded into the checksum.
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end else if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_cur_nxt       = r_cur + AW'(1);
                    w_rem_nxt       = r_rem - CW'(1);
                    if (r_rem == CW'(1)) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_FETCH;
                    end
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_out_valid_nxt = 1'b0;
                w_state_nxt     = ST_IDLE;
            end
        endcase

        // Status flags are registered copies of the state being entered.
        w_busy_nxt = (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_HOLD);
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge inclk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_cur       <= '0;
            r_rem       <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_checksum  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur       <= w_cur_nxt;
            r_rem       <= w_rem_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_addr  <= w_out_addr_nxt;
            r_out_data  <= w_out_data_nxt;
            r_checksum  <= w_checksum_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // The read address is the walk pointer itself, so it holds in IDLE.
    assign rf_raddr  = r_cur;
    assign out_valid = r_out_valid;
    assign out_addr  = r_out_addr;
    assign out_data  = r_out_data;
    assign checksum  = r_checksum;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a behavioural register file feeds rf_rdata, and each
// dump is compared against an expected word list built from the range rules.
module tb_regfile_dump;

    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned NREG = 32;

    logic          inclk;
    logic          rstn;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   count;
    logic          abort;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;
    logic [DW-1:0] checksum;

    logic [DW-1:0] regs [NREG];

    int n_checks = 0;
    int n_pass   = 0;

    regfile_dump #(.AW(AW), .DW(DW)) dut (
        .inclk      (inclk),
        .rstn       (rstn),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .abort      (abort),
        .rf_raddr   (rf_raddr),
        .rf_rdata   (rf_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    // Combinational register-file read port.
    assign rf_rdata = regs[rf_raddr];

    initial begin
        inclk = 1'b0;
        forever #5 inclk = ~inclk;
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // One complete dump: expected words are the wrapping address range read
    // from the register file as it stands when the dump is requested.
    task automatic run_dump(input int sa, input int cnt, input int pct, input int stall, input bit noise);
        logic [AW-1:0] exp_addr [$];
        logic [DW-1:0] exp_data [$];
        logic [DW-1:0] exp_sum;
        int n;
        int cyc;
        int held;
        exp_sum = '0;
        n = 0;
        cyc = 0;
        held = 0;
        for (int k = 0; k < cnt; k++) begin
            int a;
            a = (sa + k) % NREG;
            exp_addr.push_back(AW'(a));
            exp_data.push_back(regs[a]);
            exp_sum ^= regs[a];
        end
        @(negedge inclk);
        start = 1'b1; start_addr = AW'(sa); count = (AW+1)'(cnt); out_ready = 1'b0;
        @(negedge inclk);
        start = 1'b0;
        if (cnt == 0) begin
            check("zero_done", done, 1);
            check("zero_valid", out_valid, 0);
            check("zero_busy", busy, 0);
            check("zero_sum", checksum, 0);
            @(negedge inclk);
            check("zero_done_off", done, 0);
            check("zero_valid_off", out_valid, 0);
            return;
        end
        check("fetch_busy", busy, 1);
        check("fetch_valid", out_valid, 0);
        check("fetch_raddr", rf_raddr, DW'(sa));
        @(negedge inclk);
        check("latency_valid", out_valid, 1);
        while (n < cnt && cyc < 400) begin
            check("busy", busy, 1);
            check("done_early", done, 0);
            if (out_valid) begin
                check("addr", out_addr, exp_addr[n]);
                check("data", out_data, exp_data[n]);
            end
            if (out_valid && n == 0 && held < stall) begin
                out_ready = 1'b0;
                held++;
            end else begin
                out_ready = ($urandom_range(99) < pct);
            end
            if (noise) begin
                start      = 1'($urandom_range(1));
                start_addr = AW'($urandom);
                count      = (AW+1)'($urandom_range(32));
            end
            if (out_valid && out_ready) n++;
            @(negedge inclk);
            cyc++;
        end
        out_ready = 1'b0;
        start = 1'b0;
        check("accepted", n, cnt);
        if (pct == 100 && stall == 0) check("throughput", cyc, 2 * cnt - 1);
        check("done", done, 1);
        check("done_valid", out_valid, 0);
        check("checksum", checksum, exp_sum);
        @(negedge inclk);
        check("done_pulse", done, 0);
        check("idle_busy", busy, 0);
        check("idle_sum", checksum, exp_sum);
        check("idle_raddr", rf_raddr, DW'((sa + cnt) % NREG));
    endtask

    // Abort during the second word's HOLD of an 8-word dump.
    task automatic run_abort(input int sa);
        logic [DW-1:0] part;
        part = regs[sa % NREG] ^ regs[(sa + 1) % NREG];
        @(negedge inclk);
        start = 1'b1; start_addr = AW'(sa); count = 6'd8; out_ready = 1'b0;
        @(negedge inclk);
        start = 1'b0;
        @(negedge inclk);
        check("ab_first_valid", out_valid, 1);
        out_ready = 1'b1;
        @(negedge inclk);
        @(negedge inclk);
        check("ab_second_valid", out_valid, 1);
        check("ab_second_addr", out_addr, DW'((sa + 1) % NREG));
        abort = 1'b1;
        @(negedge inclk);
        abort = 1'b0; out_ready = 1'b0;
        check("ab_valid_fall", out_valid, 0);
        check("ab_busy", busy, 0);
        check("ab_no_done", done, 0);
        check("ab_partial_sum", checksum, part);
        @(negedge inclk);
        check("ab_no_done2", done, 0);
        check("ab_raddr_hold", rf_raddr, DW'((sa + 1) % NREG));
    endtask

    // A register write landing on the FETCH edge must not disturb the capture.
    task automatic run_rf_write(input int sa);
        logic [DW-1:0] old;
        old = regs[sa];
        @(negedge inclk);
        start = 1'b1; start_addr = AW'(sa); count = 6'd1; out_ready = 1'b0;
        @(negedge inclk);
        start = 1'b0;
        @(posedge inclk);
        #1 regs[sa] = ~old;
        @(negedge inclk);
        check("wr_valid", out_valid, 1);
        check("wr_data_old", out_data, old);
        out_ready = 1'b1;
        @(negedge inclk);
        out_ready = 1'b0;
        check("wr_done", done, 1);
        check("wr_sum", checksum, old);
        @(negedge inclk);
    endtask

    // Asynchronous reset while a word is being held.
    task automatic run_reset_mid_hold(input int sa);
        @(negedge inclk);
        start = 1'b1; start_addr = AW'(sa); count = 6'd4; out_ready = 1'b0;
        @(negedge inclk);
        start = 1'b0;
        @(negedge inclk);
        check("rh_valid_before", out_valid, 1);
        rstn = 1'b0;
        #1;
        check("rh_valid", out_valid, 0);
        check("rh_busy", busy, 0);
        check("rh_done", done, 0);
        check("rh_addr", out_addr, 0);
        check("rh_data", out_data, 0);
        check("rh_sum", checksum, 0);
        check("rh_raddr", rf_raddr, 0);
        @(negedge inclk);
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        start_addr = '0; count = '0;
        for (int i = 0; i < NREG; i++) regs[i] = (i == 0) ? 32'h0 : 32'h100 + 32'(i);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", out_addr, 0);
        check("rst_data", out_data, 0);
        check("rst_sum", checksum, 0);
        check("rst_raddr", rf_raddr, 0);
        @(negedge inclk);
        @(negedge inclk);
        rstn = 1'b1;

        run_dump(3, 4, 100, 0, 1'b0);
        check("basic_sum_const", checksum, 32'h0000_0004);
        run_dump(30, 4, 100, 0, 1'b0);
        run_dump(12, 3, 100, 5, 1'b0);
        run_dump(5, 0, 100, 0, 1'b0);
        run_abort(20);
        run_dump(20, 5, 100, 0, 1'b0);
        run_rf_write(7);
        run_reset_mid_hold(10);
        run_dump(9, 6, 70, 0, 1'b1);
        run_dump(0, 32, 100, 0, 1'b0);

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < NREG; i++) regs[i] = $urandom;
            run_dump(int'($urandom_range(31)), int'($urandom_range(32)),
                     int'($urandom_range(100, 30)), int'($urandom_range(3)), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
